// File: rtl/up_down_counter_mod.sv
// Up/down counter with programmable modulus, step, parallel load and
// wrap / saturate / one-shot boundary handling. All outputs registered.
module up_down_counter_mod #(
    parameter int N      = 16,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en,
    input  logic              up_or_down,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      limit,
    input  logic [1:0]        mode,
    input  logic              load,
    input  logic [N-1:0]      load_value,
    input  logic              clear_ovf,
    output logic [N-1:0]      count,
    output logic              tc,
    output logic              ovf,
    output logic              done
);

    typedef enum logic {
        S_RUN  = 1'b0,
        S_DONE = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [N-1:0] count_q, count_d;
    logic         tc_q, tc_d;
    logic         ovf_q, ovf_d;
    logic         ovf_set;

    logic [N:0]   count_x, step_x, limit_x, limit_p1;
    logic [N:0]   up_sum, up_wrap, dn_diff, dn_wrap;
    logic         is_sat, is_one;

    always_comb begin
        count_x  = {1'b0, count_q};
        step_x   = {{(N + 1 - STEP_W){1'b0}}, step};
        limit_x  = {1'b0, limit};
        limit_p1 = limit_x + 1'b1;
        up_sum   = count_x + step_x;
        up_wrap  = up_sum - limit_p1;
        dn_diff  = count_x - step_x;
        dn_wrap  = count_x + limit_p1 - step_x;
        is_sat   = (mode == 2'b01);
        is_one   = (mode == 2'b10);

        state_d  = state_q;
        count_d  = count_q;
        tc_d     = 1'b0;
        ovf_set  = 1'b0;

        if (load) begin
            count_d = (load_value > limit) ? limit : load_value;
            state_d = S_RUN;
        end else if (state_q == S_RUN && en && step != '0) begin
            if (count_q > limit) begin
                // Limit was lowered underneath the count: clamp, flag ovf, no tc.
                count_d = limit;
                ovf_set = 1'b1;
            end else if (up_or_down) begin
                if (up_sum > limit_x) begin
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                    if (is_sat || is_one) count_d = limit;
                    else                  count_d = up_wrap[N-1:0];
                    if (is_one) state_d = S_DONE;
                end else begin
                    count_d = up_sum[N-1:0];
                    if (is_one && up_sum == limit_x) begin
                        tc_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end else begin
                if (count_x < step_x) begin
                    tc_d    = 1'b1;
                    ovf_set = 1'b1;
                    if (is_sat || is_one) count_d = '0;
                    else                  count_d = dn_wrap[N-1:0];
                    if (is_one) state_d = S_DONE;
                end else begin
                    count_d = dn_diff[N-1:0];
                    if (is_one && dn_diff == '0) begin
                        tc_d    = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
        end

        // A boundary event in the same cycle as clear_ovf keeps the flag set.
        if (ovf_set)        ovf_d = 1'b1;
        else if (clear_ovf) ovf_d = 1'b0;
        else                ovf_d = ovf_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RUN;
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign ovf   = ovf_q;
    assign done  = (state_q == S_DONE);

endmodule

// File: tb/tb_up_down_counter_mod.sv
// Scoreboard bench for up_down_counter_mod: directed scenarios followed by
// randomized traffic checked against an arithmetic reference model.
module tb_up_down_counter_mod;

    localparam int N      = 16;
    localparam int STEP_W = 4;
    localparam int W      = N + 3;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              en = 1'b0;
    logic              up_or_down = 1'b0;
    logic [STEP_W-1:0] step = '0;
    logic [N-1:0]      limit = '0;
    logic [1:0]        mode = '0;
    logic              load = 1'b0;
    logic [N-1:0]      load_value = '0;
    logic              clear_ovf = 1'b0;
    logic [N-1:0]      count;
    logic              tc, ovf, done;

    up_down_counter_mod #(.N(N), .STEP_W(STEP_W)) dut (
        .clk(clk), .reset(reset), .en(en), .up_or_down(up_or_down),
        .step(step), .limit(limit), .mode(mode), .load(load),
        .load_value(load_value), .clear_ovf(clear_ovf),
        .count(count), .tc(tc), .ovf(ovf), .done(done)
    );

    always #5 clk = ~clk;

    logic [W-1:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // reference model state
    int m_count = 0;
    bit m_ovf   = 0;
    bit m_done  = 0;

    task automatic drive(input bit r, input bit ld, input int lv, input bit e,
                         input bit ud, input int st, input int lim, input int md,
                         input bit clr);
        bit m_tc;
        bit bnd;
        int range;
        @(negedge clk);
        reset = r; load = ld; load_value = lv[N-1:0]; en = e; up_or_down = ud;
        step = st[STEP_W-1:0]; limit = lim[N-1:0]; mode = md[1:0]; clear_ovf = clr;

        m_tc  = 0;
        bnd   = 0;
        range = lim + 1;
        if (r) begin
            m_count = 0; m_ovf = 0; m_done = 0;
        end else begin
            if (ld) begin
                m_count = (lv > lim) ? lim : lv;
                m_done  = 0;
            end else if (!m_done && e && st != 0) begin
                if (m_count > lim) begin
                    m_count = lim;
                    bnd     = 1;
                end else if (ud) begin
                    if (m_count + st > lim) begin
                        bnd = 1; m_tc = 1;
                        if (md == 1 || md == 2) m_count = lim;
                        else                    m_count = (m_count + st) % range;
                        if (md == 2) m_done = 1;
                    end else begin
                        m_count = m_count + st;
                        if (md == 2 && m_count == lim) begin m_tc = 1; m_done = 1; end
                    end
                end else begin
                    if (m_count < st) begin
                        bnd = 1; m_tc = 1;
                        if (md == 1 || md == 2) m_count = 0;
                        else                    m_count = (m_count - st + range) % range;
                        if (md == 2) m_done = 1;
                    end else begin
                        m_count = m_count - st;
                        if (md == 2 && m_count == 0) begin m_tc = 1; m_done = 1; end
                    end
                end
            end
            if (bnd)      m_ovf = 1;
            else if (clr) m_ovf = 0;
        end
        exp_q.push_back({m_count[N-1:0], m_tc, m_ovf, m_done});
    endtask

    // monitor: outputs are valid every cycle; one expectation per clock
    initial begin
        logic [W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                if ({count, tc, ovf, done} !== e) begin
                    n_fail++;
                    $display("FAIL cycle %0d count/tc/ovf/done got %0d/%0b/%0b/%0b want %0d/%0b/%0b/%0b",
                             cyc, count, tc, ovf, done, e[W-1:3], e[2], e[1], e[0]);
                end
            end
        end
    end

    initial begin
        int lim, st, md, lv;
        bit r, ld, e, ud, clr;

        // reset
        drive(1, 0, 0, 0, 0, 0, 9, 0, 0);
        // wrap up: 3,6,9,2,5
        drive(0, 1, 0, 0, 1, 3, 9, 0, 0);
        repeat (5) drive(0, 0, 0, 1, 1, 3, 9, 0, 0);
        // wrap down from 5: 1, 7; then clear ovf
        drive(0, 1, 5, 0, 0, 4, 9, 0, 1);
        repeat (2) drive(0, 0, 0, 1, 0, 4, 9, 0, 0);
        drive(0, 0, 0, 0, 0, 4, 9, 0, 1);
        drive(0, 0, 0, 0, 0, 4, 9, 0, 0);
        // saturate up from 90, then down from 10
        drive(0, 1, 90, 0, 1, 15, 100, 1, 0);
        repeat (3) drive(0, 0, 0, 1, 1, 15, 100, 1, 0);
        drive(0, 1, 10, 0, 0, 15, 100, 1, 1);
        repeat (2) drive(0, 0, 0, 1, 0, 15, 100, 1, 0);
        // one-shot to 5, hold, reload 2 and resume
        drive(0, 1, 0, 0, 1, 1, 5, 2, 1);
        repeat (7) drive(0, 0, 0, 1, 1, 1, 5, 2, 0);
        drive(0, 0, 0, 1, 1, 1, 5, 0, 0);
        drive(0, 1, 2, 1, 1, 1, 5, 2, 0);
        repeat (2) drive(0, 0, 0, 1, 1, 1, 5, 2, 0);
        // load beats en; clamp 200 -> 50; reset at 37
        drive(0, 1, 7, 1, 1, 3, 50, 0, 0);
        drive(0, 1, 200, 1, 1, 3, 50, 0, 0);
        drive(0, 1, 30, 0, 1, 7, 50, 0, 0);
        drive(0, 0, 0, 1, 1, 7, 50, 0, 0);
        drive(1, 0, 0, 1, 1, 7, 50, 0, 0);
        // step 0 freezes
        drive(0, 1, 12, 0, 1, 0, 50, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 1, 0, 50, 0, 0);
        // limit lowered under count
        drive(0, 1, 30, 0, 1, 1, 50, 0, 0);
        drive(0, 0, 0, 1, 1, 1, 20, 0, 0);
        drive(0, 0, 0, 1, 0, 1, 20, 0, 0);
        // limit 0 wrap
        drive(0, 1, 9, 0, 1, 1, 0, 0, 1);
        repeat (3) drive(0, 0, 0, 1, 1, 1, 0, 0, 0);
        repeat (2) drive(0, 0, 0, 1, 0, 1, 0, 3, 0);

        // randomized traffic
        lim = 20;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 19) == 0) lim = $urandom_range(0, 60);
            st  = $urandom_range(0, (lim + 1 < 15) ? lim + 1 : 15);
            md  = $urandom_range(0, 3);
            ud  = $urandom_range(0, 1);
            e   = ($urandom_range(0, 9) < 8);
            ld  = ($urandom_range(0, 19) == 0);
            lv  = $urandom_range(0, 80);
            clr = ($urandom_range(0, 9) == 0);
            r   = ($urandom_range(0, 199) == 0);
            drive(r, ld, lv, e, ud, st, lim, md, clr);
        end

        @(negedge clk);
        en = 1'b0; load = 1'b0; reset = 1'b0; clear_ovf = 1'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain pending got %0d want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
